// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM between the MSX-bus path (A), a loader (B) and refresh.
// A has priority; B accesses run to completion; a starvation guard lets B past refresh.
module ram_arbiter #(
    parameter int ADDR_WIDTH    = 22,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [7:0]            A_DIN,
    input  logic                  A_OE_n,
    input  logic                  A_WE_n,
    input  logic                  A_RFSH_n,
    output logic [7:0]            A_DOUT,
    output logic                  A_WAIT_n,
    input  logic                  B_REQ,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [7:0]            B_DIN,
    output logic                  B_ACK,
    output logic [7:0]            B_DOUT,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [7:0]            RAM_DIN,
    output logic                  RAM_WE_n,
    output logic                  RAM_OE_n,
    output logic                  RAM_RFSH_n,
    input  logic [15:0]           RAM_DOUT
);
    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, RFSH} state_t;
    state_t state, next_state;
    logic [3:0] cnt, starve;
    logic rfsh_pend, rfsh_q, a_wait_q, b_ack_q;
    logic [7:0] b_dout_q;
    logic a_req, rfsh_fall, b_done, a_exit, b_start, r_start;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [7:0] din_d;
    logic we_d, oe_d, rf_d;
    logic unused_hi;
    assign unused_hi = ^RAM_DOUT[15:8];
    assign a_req     = !A_OE_n || !A_WE_n;
    assign rfsh_fall = rfsh_q && !A_RFSH_n;
    assign b_done    = state == GNT_B && cnt == 4'd0;
    assign a_exit    = state == GNT_A && next_state != GNT_A;
    assign b_start   = next_state == GNT_B && state != GNT_B;
    assign r_start   = next_state == RFSH && state != RFSH;
    always_ff @(posedge CLK) begin
        state <= RESET ? IDLE : next_state;
    end
    // Saturated starvation count forces B ahead of refresh (never ahead of A).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  next_state = a_req ? GNT_A :
                                (B_REQ && starve == 4'hF) ? GNT_B :
                                rfsh_pend ? RFSH :
                                B_REQ ? GNT_B : IDLE;
            GNT_A: next_state = a_req ? GNT_A : IDLE;
            GNT_B: next_state = cnt != 4'd0 ? GNT_B : a_req ? GNT_A : IDLE;
            RFSH:  next_state = cnt != 4'd0 ? RFSH : IDLE;
        endcase
    end
    // RAM-side values are computed from the next state and registered, so the
    // RAM sees each grant one cycle after the decision; a running B access holds.
    always_comb begin
        addr_d = '0;
        din_d  = '0;
        we_d   = 1'b1;
        oe_d   = 1'b1;
        rf_d   = 1'b1;
        if (next_state == GNT_A) begin
            addr_d = A_ADDR;
            din_d  = A_DIN;
            we_d   = A_WE_n;
            oe_d   = A_OE_n;
        end else if (next_state == GNT_B) begin
            addr_d = state == GNT_B ? RAM_ADDR : B_ADDR;
            din_d  = state == GNT_B ? RAM_DIN : B_DIN;
            we_d   = state == GNT_B ? RAM_WE_n : !B_WE;
            oe_d   = state == GNT_B ? RAM_OE_n : B_WE;
        end else if (next_state == RFSH) begin
            rf_d = 1'b0;
        end
    end
    assign A_DOUT   = (state == GNT_A && !A_OE_n) ? RAM_DOUT[7:0] : 8'h00;
    assign A_WAIT_n = a_wait_q;
    assign B_ACK    = b_ack_q;
    assign B_DOUT   = b_ack_q ? RAM_DOUT[7:0] : b_dout_q;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt        <= '0;
            starve     <= '0;
            rfsh_pend  <= 1'b0;
            rfsh_q     <= 1'b1;
            a_wait_q   <= 1'b1;
            b_ack_q    <= 1'b0;
            b_dout_q   <= '0;
            RAM_ADDR   <= '0;
            RAM_DIN    <= '0;
            RAM_WE_n   <= 1'b1;
            RAM_OE_n   <= 1'b1;
            RAM_RFSH_n <= 1'b1;
        end else begin
            cnt        <= b_start ? 4'(ACCESS_CYCLES - 1) : r_start ? 4'd1 :
                          cnt != 4'd0 ? cnt - 4'd1 : cnt;
            starve     <= b_done ? 4'd0 :
                          (a_exit && B_REQ && starve != 4'hF) ? starve + 4'd1 : starve;
            rfsh_pend  <= rfsh_fall || (rfsh_pend && !(state == RFSH && cnt == 4'd0));
            rfsh_q     <= A_RFSH_n;
            a_wait_q   <= !(a_req && state == GNT_B && cnt != 4'd0);
            b_ack_q    <= state == GNT_B && cnt == 4'd1;
            b_dout_q   <= b_done ? RAM_DOUT[7:0] : b_dout_q;
            RAM_ADDR   <= addr_d;
            RAM_DIN    <= din_d;
            RAM_WE_n   <= we_d;
            RAM_OE_n   <= oe_d;
            RAM_RFSH_n <= rf_d;
        end
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 22: width of all RAM addresses.
REQ-002 Parameter ACCESS_CYCLES, default 4, legal range 2..15: cycles a port-B access occupies the RAM.
REQ-003 CLK  in  1  system clock; single clock domain.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 A_ADDR  in  ADDR_WIDTH  MSX-bus path address, from the megarom controller RAM port.
REQ-006 A_DIN  in  8  MSX-bus path write data.
REQ-007 A_OE_n  in  1  MSX-bus path read strobe, active low, level-held for the bus cycle.
REQ-008 A_WE_n  in  1  MSX-bus path write strobe, active low, level-held for the bus cycle.
REQ-009 A_RFSH_n  in  1  refresh request, active low.
REQ-010 A_DOUT  out  8  read data returned to the MSX-bus path.
REQ-011 A_WAIT_n  out  1  low while a port-A request is stalled behind a port-B access.
REQ-012 B_REQ  in  1  loader request, level.
REQ-013 B_WE  in  1  loader direction: 1 = write, 0 = read.
REQ-014 B_ADDR  in  ADDR_WIDTH  loader address.
REQ-015 B_DIN  in  8  loader write data.
REQ-016 B_ACK  out  1  one-cycle pulse marking completion of a loader access.
REQ-017 B_DOUT  out  8  loader read data, valid from the B_ACK cycle until the next B_ACK.
REQ-018 RAM_ADDR, RAM_DIN, RAM_WE_n, RAM_OE_n, RAM_RFSH_n  out  ADDR_WIDTH/8/1/1/1  RAM-side request.
REQ-019 RAM_DOUT  in  16  RAM read data; bits [7:0] are used.

Function
REQ-020 The FSM SHALL have four states: IDLE, GNT_A, GNT_B and RFSH.
REQ-021 A request (a_req) SHALL be true when !A_OE_n || !A_WE_n.
REQ-022 In IDLE, priority SHALL be a_req, then pending refresh, then B_REQ.
- Simultaneous a_req and B_REQ: A is granted; B waits.
REQ-023 IDLE to GNT_A SHALL occur on a_req.
- RAM outputs follow the A inputs one cycle later, registered.
- GNT_A is held while a_req remains true.
- The FSM returns to IDLE in the cycle after a_req drops.
REQ-024 Entering GNT_B SHALL latch B_ADDR, B_DIN and B_WE and load a down-counter with ACCESS_CYCLES-1.
- RAM_WE_n = !latched_we; RAM_OE_n = latched_we.
- When the counter reaches 0: B_ACK pulses for 1 cycle, B_DOUT captures RAM_DOUT[7:0], and the FSM returns to IDLE.
REQ-025 A GNT_B access SHALL never be aborted.
- If B_REQ drops mid-access, the access still completes and B_ACK still pulses.
- A new B access requires B_REQ high in IDLE; the requester drops B_REQ on B_ACK to avoid a repeat.
REQ-026 a_req in GNT_B SHALL drive A_WAIT_n low from the next cycle.
- A_WAIT_n returns high in the cycle GNT_A is entered.
- The FSM goes directly GNT_B to GNT_A, skipping IDLE.
REQ-027 A falling edge of A_RFSH_n SHALL set a refresh-pending flag.
- The flag is serviced from IDLE: RFSH drives RAM_RFSH_n low for 2 cycles, then the flag clears and the FSM returns to IDLE.
- A second edge while the flag is set is merged.
REQ-028 Outside their grant state, RAM outputs SHALL be idle: ADDR 0, DIN 0, WE_n 1, OE_n 1, RFSH_n 1.
REQ-029 A_DOUT SHALL equal RAM_DOUT[7:0] while in GNT_A with A_OE_n low, else 0.
REQ-030 Starvation guard: a 4-bit counter SHALL increment on each GNT_A exit while B_REQ is high, and clear on B_ACK.
- At 15, B is granted ahead of refresh; A keeps priority.

Reset
REQ-031 RESET high at a CLK edge SHALL force:
- state IDLE, all counters 0, refresh flag 0;
- B_ACK 0, B_DOUT 0, A_DOUT 0, A_WAIT_n 1;
- all RAM outputs idle.
REQ-032 RESET asserted mid-access SHALL abandon the access; no B_ACK is issued for it.

Verification
REQ-033 B write, ACCESS_CYCLES=4, B_ADDR=0x01234, B_DIN=0x5A, no A traffic -> RAM_WE_n low 4 cycles at 0x01234/0x5A; B_ACK pulses once on the 4th cycle.
REQ-034 A_OE_n and B_REQ rise together in IDLE, A_ADDR=0x00100, RAM_DOUT=0x00C3 -> GNT_A first; A_DOUT=0xC3; the B access starts after A_OE_n returns high.
REQ-035 A_WE_n falls 1 cycle into a B read -> A_WAIT_n low for the remaining B cycles; B_ACK pulses; next cycle RAM_WE_n low with A data; A_WAIT_n high.
REQ-036 A_RFSH_n pulse during GNT_A -> RAM_RFSH_n low exactly 2 cycles after A ends; two pulses during the same GNT_A give a single refresh.
REQ-037 RESET asserted during cycle 2 of a B write -> next cycle all RAM outputs idle, state IDLE, no B_ACK.
REQ-038 B_REQ high through 15 consecutive A grants with a refresh pending -> B is granted before refresh; starvation counter is 0 after B_ACK.
